cod_binario16x4: RTL and testbench



---
 rtl/cod_binario16x4.sv | 57 +++++
 tb/tb_cod_binario16x4.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cod_binario16x4.sv
`default_nettype none
// ============================================================================
//  Module   : cod_binario16x4
//  Brief    : Registered 16-to-4 priority encoder with valid and multi flags.
//  Revision : 1.0 - initial release
// ============================================================================
module cod_binario16x4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    output logic [3:0]  out,
    output logic        valid,
    output logic        multi
);

    localparam int C_WIDTH = 16;

    logic [3:0] w_idx;
    logic       w_valid;
    logic       w_multi;

    logic [3:0] r_out;
    logic       r_valid;
    logic       r_multi;

    // Ascending scan so the last hit, i.e. the highest set bit, wins.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < C_WIDTH; i++) begin
            if (in[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign w_valid = |in;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(in & (in - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= 4'd0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_out   <= w_idx;
            r_valid <= w_valid;
            r_multi <= w_multi;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign multi = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_cod_binario16x4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cod_binario16x4
//  Brief    : Scoreboard bench for the registered 16-to-4 priority encoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cod_binario16x4;

    typedef struct {
        logic [3:0] out;
        logic       valid;
        logic       multi;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [3:0]  out;
    logic        valid;
    logic        multi;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    cod_binario16x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out),
        .valid (valid),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] v);
        exp_t e;
        e.out = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) e.out = 4'(i);
        end
        e.valid = (v != 16'd0);
        e.multi = ($countones(v) > 1);
        return e;
    endfunction

    // Drives one sample half a cycle ahead of the edge and records its expectation.
    task automatic apply(input logic [15:0] v);
        @(negedge clk);
        in = v;
        sb.push_back(model(v));
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in    = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({out, valid, multi} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d: got out=%0d valid=%b multi=%b, want 0/0/0", c, out, valid, multi);
            end
        end
    endtask

    task automatic test_release;
        exp_t e;
        logic [15:0] seq [2] = '{16'h0000, 16'h0001};
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                in = seq[k];
                sb.push_back(model(seq[k]));
            end else begin
                apply(seq[k]);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL release%0d: scoreboard empty", k);
            end else begin
                e = sb.pop_front();
                if ({out, valid, multi} !== {e.out, e.valid, e.multi}) begin
                    miscompares++;
                    $display("FAIL release%0d: got %0d/%b/%b, want %0d/%b/%b", k, out, valid, multi, e.out, e.valid, e.multi);
                end
            end
        end
    endtask

    task automatic test_directed;
        exp_t e;
        logic [15:0] vecs [6] = '{16'h2000, 16'h0800, 16'h0008, 16'h8001, 16'h0006, 16'hFFFF};
        foreach (vecs[k]) begin
            apply(vecs[k]);
            @(posedge clk);
            #1;
            vectors++;
            e = sb.pop_front();
            if ({out, valid, multi} !== {e.out, e.valid, e.multi}) begin
                miscompares++;
                $display("FAIL directed in=%h: got %0d/%b/%b, want %0d/%b/%b", vecs[k], out, valid, multi, e.out, e.valid, e.multi);
            end
        end
    endtask

    task automatic test_sweep;
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            apply(16'd1 << k);
            @(posedge clk);
            #1;
            vectors++;
            e = sb.pop_front();
            if ({out, valid, multi} !== {e.out, e.valid, e.multi}) begin
                miscompares++;
                $display("FAIL sweep k=%0d: got %0d/%b/%b, want %0d/%b/%b", k, out, valid, multi, e.out, e.valid, e.multi);
            end
        end
    endtask

    task automatic test_hold;
        exp_t e;
        apply(16'h0800);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if ({out, valid, multi} !== {e.out, e.valid, e.multi}) begin
            miscompares++;
            $display("FAIL hold_sample: got %0d/%b/%b, want %0d/%b/%b", out, valid, multi, e.out, e.valid, e.multi);
        end
        #2;
        in = 16'h00F1;
        #1;
        vectors++;
        if ({out, valid, multi} !== {e.out, e.valid, e.multi}) begin
            miscompares++;
            $display("FAIL hold_between_edges: got %0d/%b/%b, want %0d/%b/%b", out, valid, multi, e.out, e.valid, e.multi);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [15:0] v;
        for (int k = 0; k < 40; k++) begin
            v = 16'($urandom);
            if (k % 5 == 0) v = 16'd1 << (k % 16);
            if (k == 7) v = 16'h0000;
            apply(v);
            @(posedge clk);
            #1;
            vectors++;
            e = sb.pop_front();
            if ({out, valid, multi} !== {e.out, e.valid, e.multi}) begin
                miscompares++;
                $display("FAIL b2b k=%0d in=%h: got %0d/%b/%b, want %0d/%b/%b", k, v, out, valid, multi, e.out, e.valid, e.multi);
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        apply(16'h2000);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if ({out, valid, multi} !== {e.out, e.valid, e.multi}) begin
            miscompares++;
            $display("FAIL async_pre: got %0d/%b/%b, want %0d/%b/%b", out, valid, multi, e.out, e.valid, e.multi);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out, valid, multi} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_immediate: got %0d/%b/%b, want 0/0/0", out, valid, multi);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({out, valid, multi} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_held: got %0d/%b/%b, want 0/0/0", out, valid, multi);
        end
        sb.delete();
        @(negedge clk);
        in    = 16'h0008;
        rst_n = 1'b1;
        sb.push_back(model(16'h0008));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if ({out, valid, multi} !== {e.out, e.valid, e.multi}) begin
            miscompares++;
            $display("FAIL async_post: got %0d/%b/%b, want %0d/%b/%b", out, valid, multi, e.out, e.valid, e.multi);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_directed();
        test_sweep();
        test_hold();
        test_back_to_back();
        test_async_reset();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
